// File: rtl/cam_pkg.sv
// Shared types and default sizing for the CAM write-allocation slice.
package cam_pkg;

    typedef enum logic {IDLE, CLEAR} cam_alloc_state_e;

    localparam int CAM_WIDTH      = 32;
    localparam int CAM_ADDR_WIDTH = 5;

endpackage

// File: rtl/cam_free_finder.sv
// Find-first-zero priority encoder: reports the lowest-index clear bit of a valid vector.
module cam_free_finder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic [DEPTH-1:0]      i_valid,
    output logic                  o_found,
    output logic [ADDR_WIDTH-1:0] o_index
);

    // Scan high to low so the last hit (lowest index) is the one that sticks.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_found = 1'b1;
                o_index = ADDR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/cam_write_alloc.sv
// CAM write allocation: picks a free entry (else round-robin victim), drives the registered
// write strobe, tracks per-entry valid bits, and clears the whole array out of reset or on flush.
module cam_write_alloc
    import cam_pkg::*;
#(
    parameter int WIDTH      = CAM_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic [WIDTH-1:0]      req_data_i,
    output logic                  req_ready_o,
    input  logic                  inval_i,
    input  logic [ADDR_WIDTH-1:0] inval_index_i,
    input  logic                  flush_i,
    output logic                  write_enable_o,
    output logic [ADDR_WIDTH-1:0] write_index_o,
    output logic [WIDTH-1:0]      write_data_o,
    output logic                  evict_o,
    output logic [DEPTH-1:0]      valid_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o
);

    cam_alloc_state_e r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] r_victim;
    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_evict;

    logic                  w_idle;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] w_free_idx;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_accept;
    logic                  w_evict;
    logic                  w_inval;
    logic [DEPTH-1:0]      w_valid_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    cam_free_finder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_free_finder (
        .i_valid (r_valid),
        .o_found (w_found),
        .o_index (w_free_idx)
    );

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && req_valid_i && !flush_i;
    assign w_evict  = !w_found;
    assign w_target = w_found ? w_free_idx : r_victim;

    // An invalidate aimed at the entry being allocated this cycle loses to the allocation.
    assign w_inval = w_idle && inval_i && !flush_i && r_valid[inval_index_i]
                     && !(w_accept && (inval_index_i == w_target));

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_inval)  w_valid_nxt[inval_index_i] = 1'b0;
        if (w_accept) w_valid_nxt[w_target]      = 1'b1;
    end

    always_comb begin
        w_count_nxt = r_count;
        if ((w_accept && !w_evict) && !w_inval)
            w_count_nxt = r_count + 1'b1;
        else if (w_inval && !(w_accept && !w_evict))
            w_count_nxt = r_count - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (flush_i) w_state_nxt = CLEAR;
            CLEAR:   if (!flush_i && (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1))) w_state_nxt = IDLE;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_victim  <= '0;
            r_valid   <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_widx    <= '0;
            r_wdata   <= '0;
            r_evict   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_we      <= 1'b1;
                r_widx    <= r_clr_cnt;
                r_wdata   <= '0;
                r_evict   <= 1'b0;
                r_clr_cnt <= flush_i ? '0 : r_clr_cnt + 1'b1;
                r_valid   <= '0;
                r_count   <= '0;
                r_victim  <= '0;
            end else if (flush_i) begin
                // Same-cycle request and invalidate are dropped; the clear starts next cycle.
                r_we      <= 1'b0;
                r_clr_cnt <= '0;
                r_valid   <= '0;
                r_count   <= '0;
                r_victim  <= '0;
            end else begin
                r_we    <= w_accept;
                r_valid <= w_valid_nxt;
                r_count <= w_count_nxt;
                if (w_accept) begin
                    r_widx  <= w_target;
                    r_wdata <= req_data_i;
                    r_evict <= w_evict;
                    if (w_evict) r_victim <= r_victim + 1'b1;
                end
            end
        end
    end

    assign req_ready_o    = w_idle;
    assign write_enable_o = r_we;
    assign write_index_o  = r_widx;
    assign write_data_o   = r_wdata;
    assign evict_o        = r_evict;
    assign valid_o        = r_valid;
    assign count_o        = r_count;
    assign full_o         = (r_count == (ADDR_WIDTH + 1)'(DEPTH));

endmodule

// File: tb/tb_cam_write_alloc.sv
// Directed bench for cam_write_alloc: expected writes are queued on drive and popped on each strobe.
module tb_cam_write_alloc;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
        logic          evict;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [W-1:0]  req_data = '0;
    logic          req_ready;
    logic          inval = 1'b0;
    logic [AW-1:0] inval_idx = '0;
    logic          flush = 1'b0;
    logic          we;
    logic [AW-1:0] widx;
    logic [W-1:0]  wdata;
    logic          evict;
    logic [D-1:0]  valid;
    logic [AW:0]   count;
    logic          full;

    int  errors = 0;
    int  checks = 0;
    wr_t sb[$];

    cam_write_alloc #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .inval_i        (inval),
        .inval_index_i  (inval_idx),
        .flush_i        (flush),
        .write_enable_o (we),
        .write_index_o  (widx),
        .write_data_o   (wdata),
        .evict_o        (evict),
        .valid_o        (valid),
        .count_o        (count),
        .full_o         (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] i, input logic [W-1:0] d, input logic e);
        wr_t t;
        t.idx = i; t.data = d; t.evict = e;
        sb.push_back(t);
    endtask

    task automatic push_clear(input int from, input int to);
        for (int i = from; i <= to; i++) push(AW'(i), '0, 1'b0);
    endtask

    // One accepted request; caller is at a negedge, returns at the next negedge.
    task automatic req(input logic [W-1:0] d, input int exp_idx, input logic exp_ev);
        chk("ready_before_req", 64'(req_ready), 64'd1);
        push(AW'(exp_idx), d, exp_ev);
        req_valid = 1'b1;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Strobe monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && we) begin
            wr_t obs;
            obs.idx = widx; obs.data = wdata; obs.evict = evict;
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(obs), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write", 64'(obs), 64'(e));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", 64'(we), 0);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_valid", 64'(valid), 0);
        chk("rst_outs", 64'({widx, wdata, evict}), 0);

        // Clear out of reset: 32 strobes, ready low until the last one lands
        push_clear(0, D - 1);
        rst_n = 1'b1;
        for (int i = 0; i < D - 1; i++) begin
            @(negedge clk);
            chk("clear_ready_low", 64'(req_ready), 0);
        end
        @(negedge clk);
        chk("post_clear_ready", 64'(req_ready), 1);
        chk("post_clear_count", 64'(count), 0);
        chk("post_clear_valid", 64'(valid), 0);

        // Fill every entry back to back
        for (int i = 0; i < D; i++) req(32'h100 + W'(i), i, 1'b0);
        chk("fill_full", 64'(full), 1);
        chk("fill_count", 64'(count), 32);
        chk("fill_valid", 64'(valid), 64'hFFFF_FFFF);

        // Full: round-robin victims 0 then 1
        req(32'h200, 0, 1'b1);
        req(32'h201, 1, 1'b1);
        chk("evict_count", 64'(count), 32);

        // Invalidate 5, then refill it without eviction
        inval = 1'b1; inval_idx = 5;
        @(negedge clk);
        inval = 1'b0;
        chk("inval5_count", 64'(count), 31);
        chk("inval5_valid", 64'(valid[5]), 0);
        chk("inval5_full", 64'(full), 0);
        req(32'hABC, 5, 1'b0);
        chk("refill5_count", 64'(count), 32);

        // Request (victim 2) plus invalidate 3 in the same cycle
        inval = 1'b1; inval_idx = 3;
        req(32'h300, 2, 1'b1);
        inval = 1'b0;
        chk("combo_valid3", 64'(valid[3]), 0);
        chk("combo_valid2", 64'(valid[2]), 1);
        chk("combo_count", 64'(count), 31);

        // Invalidate hitting the allocation target: allocation wins
        inval = 1'b1; inval_idx = 3;
        req(32'h301, 3, 1'b0);
        inval = 1'b0;
        chk("collide_valid3", 64'(valid[3]), 1);
        chk("collide_count", 64'(count), 32);

        // Invalidate twice: second is a no-op
        inval = 1'b1; inval_idx = 7;
        @(negedge clk);
        chk("inval7_count", 64'(count), 31);
        @(negedge clk);
        inval = 1'b0;
        chk("inval7_again_count", 64'(count), 31);

        // Flush from IDLE with a same-cycle request that must be dropped
        flush = 1'b1; req_valid = 1'b1; req_data = 32'hDEAD;
        push_clear(0, D - 1);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(valid), 0);
        chk("flush_ready", 64'(req_ready), 0);
        repeat (D) @(negedge clk);
        chk("flush_done_ready", 64'(req_ready), 1);

        // Ten entries, then flush and re-flush on clear cycle 4
        for (int i = 0; i < 10; i++) req(32'h400 + W'(i), i, 1'b0);
        chk("ten_count", 64'(count), 10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        push_clear(0, 4);
        push_clear(0, D - 1);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (D - 1) @(negedge clk);
        chk("reflush_busy", 64'(req_ready), 0);
        @(negedge clk);
        chk("reflush_ready", 64'(req_ready), 1);
        chk("reflush_count", 64'(count), 0);
        chk("reflush_valid", 64'(valid), 0);

        // Victim pointer back at 0: fill, then first eviction targets 0
        for (int i = 0; i < D; i++) req(32'h500 + W'(i), i, 1'b0);
        req(32'h600, 0, 1'b1);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_write_alloc.md
Name: cam_write_alloc

Overview:
- Allocation and write-control stage that sits directly upstream of the CAM write-enable decoder and the CAM storage array.
- Accepts write requests over a valid/ready handshake and picks the target entry: lowest free entry first, otherwise a round-robin victim.
- Drives the registered write enable, write index and write data consumed by the decoder and array.
- Tracks per-entry valid bits for match qualification, and supports single-entry invalidate and whole-array flush; the flush also runs automatically out of reset.

Parameters:
- WIDTH, 32, data/key width of one CAM entry.
- ADDR_WIDTH, 5, entry index width.
- DEPTH, 1<<ADDR_WIDTH, number of entries. Must equal 2**ADDR_WIDTH.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  write request valid.
- req_data_i  input  WIDTH  data to store.
- req_ready_o  output  1  block can accept a request this cycle.
- inval_i  input  1  invalidate one entry.
- inval_index_i  input  ADDR_WIDTH  entry to invalidate.
- flush_i  input  1  start a full-array clear.
- write_enable_o  output  1  one-cycle write strobe to the decoder.
- write_index_o  output  ADDR_WIDTH  target entry; feeds the decoder index input.
- write_data_o  output  WIDTH  data to the array.
- evict_o  output  1  qualifies write_enable_o: a valid entry is being overwritten.
- valid_o  output  DEPTH  per-entry valid bits.
- count_o  output  ADDR_WIDTH+1  number of valid entries.
- full_o  output  1  count_o == DEPTH.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - Victim pointer, valid_o, count_o, write_enable_o, write_index_o, write_data_o and evict_o go to 0.
  - req_ready_o is 0 and full_o is 0.
- FSM states are IDLE and CLEAR.
- CLEAR state:
  - One write per cycle: write_enable_o=1, write_index_o=clear counter, write_data_o=0, evict_o=0.
  - Counter increments each cycle; after index DEPTH-1 is written the FSM moves to IDLE. A full clear takes exactly DEPTH cycles.
  - valid_o and count_o are 0 throughout, and the victim pointer is reset to 0.
  - req_ready_o=0; requests and inval_i are ignored.
- IDLE state:
  - req_ready_o=1. A request is accepted when req_valid_i & req_ready_o.
  - If any valid bit is 0, the target is the lowest-index invalid entry and evict_o=0.
  - If all valid bits are 1, the target is the victim pointer and evict_o=1; the pointer then increments, wrapping DEPTH-1 to 0.
- Latency:
  - Outputs are registered. write_enable_o pulses high for exactly one cycle, the cycle after acceptance.
  - write_index_o, write_data_o and evict_o are valid in that cycle. They hold their last value otherwise; only the enable is qualified.
- Back-to-back requests are accepted every cycle with no bubble.
- The valid bit of the target is set in the same edge as the output registers.
- Invalidate (IDLE only):
  - Clears valid[inval_index_i] at the next edge.
  - Invalidating an already-invalid entry is a no-op.
- Simultaneous accept and invalidate in one cycle:
  - The target is chosen from the pre-cycle valid vector.
  - If the invalidate index equals the target, the allocation wins and the entry ends valid.
  - Otherwise both take effect.
- count_o arithmetic:
  - +1 on a non-evicting allocation; -1 on an invalidate of a valid entry not overridden by the allocation.
  - Both in one cycle give a net change of 0.
  - count_o never exceeds DEPTH and never underflows.
- flush_i:
  - In IDLE: moves to CLEAR next cycle, discarding any same-cycle request and invalidate.
  - In CLEAR: restarts the clear counter at 0.
- Reset asserted mid-operation aborts everything immediately; the clear restarts on release.

Decomposition:
- cam_pkg holds:
  - typedef enum logic {IDLE, CLEAR} cam_alloc_state_e;
  - localparams for the default WIDTH and ADDR_WIDTH.
- One sub-module: cam_free_finder. It is a parameterized find-first-zero priority encoder over valid_o that outputs a found flag and an ADDR_WIDTH index. It is purely combinational and reusable.

Test Plan:
- Reset release -> write_enable_o high for 32 consecutive cycles with write_index_o 0..31 and write_data_o 0, and req_ready_o 0 throughout. Then req_ready_o=1, count_o=0, valid_o=0.
- 32 back-to-back requests with data 0x100+i -> indices 0..31 one cycle later, evict_o=0. Then full_o=1, count_o=32, valid_o=32'hFFFF_FFFF.
- With the array full, 33rd and 34th requests -> index 0 then index 1, evict_o=1, count_o stays 32.
- With the array full, inval index 5, then request 0xABC -> write_index_o=5, evict_o=0, count_o goes 31 then 32.
- Array full with victim pointer at 2; request plus inval index 3 in the same cycle -> write to index 2 with evict_o=1, valid[3]=0, count_o=31.
- Assert flush_i with 10 entries valid; assert flush_i again on clear cycle 4 -> the clear restarts at index 0 and completes 32 cycles later. Then count_o=0, the victim pointer is 0, and the next request goes to index 0.
